// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-stage types and constants: state encoding, PC step, buffer entry layout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instruction_fetch_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INCR          = 32'd4;

  typedef enum logic [1:0] {
    F_IDLE  = 2'd0,
    F_WAIT  = 2'd1,
    F_DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Instructions are word aligned; the low two target bits carry no meaning.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_buffer.sv
// Small synchronous FIFO holding fetched {instr, pc} entries toward decode.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: pushes while full are dropped (caller guarantees this never happens); flush wins over push/pop.
module fetch_buffer #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head_dat
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the buffer outright.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Entry storage; contents need no reset because empty masks the head.
  always_ff @(posedge i_Clock) begin
    if (do_push && !flush) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues one instruction-memory read at a time, buffers results for decode.
// Latency: issue N, memory valid N+1 (ROM), entry at decode N+2; one instruction per 2 cycles sustained.
// Backpressure: issue only with a free buffer slot; memory request held stable until valid; redirects drain in-flight reads.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            i_Clock,
  input  logic            i_Reset,
  input  logic            i_Halt,
  input  logic            i_Redirect_Valid,
  input  logic [XLEN-1:0] i_Redirect_Target,
  output logic            o_Mem_Enable,
  output logic [XLEN-1:0] o_Mem_Addr,
  input  logic [XLEN-1:0] i_Mem_Instruction,
  input  logic            i_Mem_Instruction_Valid,
  output logic            o_Instr_Valid,
  output logic [XLEN-1:0] o_Instr,
  output logic [XLEN-1:0] o_Instr_PC,
  input  logic            i_Decode_Ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t    state;
  fetch_state_t    state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pending;

  logic            can_issue;
  logic            push;
  logic            pop;
  logic            flush;
  logic            pc_we;
  logic [XLEN-1:0] pc_d;
  logic            pend_we;
  logic [XLEN-1:0] pend_d;
  logic [XLEN-1:0] redirect_pc;

  logic             buf_full;
  logic             buf_empty;
  logic [CNT_W-1:0] buf_count;
  fetch_entry_t     push_entry;
  fetch_entry_t     head_entry;

  assign redirect_pc = align_pc(i_Redirect_Target);

  // Registered count only: a same-cycle pop never frees the slot for this issue,
  // which reserves room for the in-flight response.
  assign can_issue = !i_Reset && (state == F_IDLE) && !i_Halt && !i_Redirect_Valid
                     && (buf_count < CNT_W'(FIFO_DEPTH));

  // Enable stays up through the valid cycle so the memory leaves its response state.
  assign o_Mem_Enable = can_issue || (state == F_WAIT) || (state == F_DRAIN);
  assign o_Mem_Addr   = r_pc;

  assign pop           = o_Instr_Valid && i_Decode_Ready;
  assign o_Instr_Valid = !buf_empty;
  assign o_Instr       = head_entry.instr;
  assign o_Instr_PC    = head_entry.pc;
  assign push_entry    = '{instr: i_Mem_Instruction, pc: r_pc};

  // State register.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) state <= F_IDLE;
    else         state <= state_nxt;
  end

  // Next-state: one read outstanding at a time; a redirect mid-read waits for its response in F_DRAIN.
  always_comb begin
    state_nxt = state;
    unique case (state)
      F_IDLE:  if (can_issue) state_nxt = F_WAIT;
      F_WAIT: begin
        if (i_Mem_Instruction_Valid) state_nxt = F_IDLE;
        else if (i_Redirect_Valid)   state_nxt = F_DRAIN;
      end
      F_DRAIN: if (i_Mem_Instruction_Valid) state_nxt = F_IDLE;
      default: state_nxt = F_IDLE;
    endcase
  end

  // Outputs: buffer push/flush and PC / pending-target updates per state.
  always_comb begin
    push    = 1'b0;
    flush   = 1'b0;
    pc_we   = 1'b0;
    pc_d    = r_pc;
    pend_we = 1'b0;
    pend_d  = r_pending;
    unique case (state)
      F_IDLE: begin
        if (i_Redirect_Valid) begin
          flush = 1'b1;
          pc_we = 1'b1;
          pc_d  = redirect_pc;
        end
      end
      F_WAIT: begin
        if (i_Mem_Instruction_Valid && !i_Redirect_Valid) begin
          push  = 1'b1;
          pc_we = 1'b1;
          pc_d  = r_pc + PC_INCR;
        end else if (i_Redirect_Valid && !i_Mem_Instruction_Valid) begin
          flush   = 1'b1;
          pend_we = 1'b1;
          pend_d  = redirect_pc;
        end else if (i_Redirect_Valid && i_Mem_Instruction_Valid) begin
          // Response belongs to the old path: drop it and jump straight away.
          flush = 1'b1;
          pc_we = 1'b1;
          pc_d  = redirect_pc;
        end
      end
      F_DRAIN: begin
        if (i_Redirect_Valid) begin
          flush   = 1'b1;
          pend_we = 1'b1;
          pend_d  = redirect_pc;
        end
        if (i_Mem_Instruction_Valid) begin
          // Newest redirect wins, even when it lands on the response cycle.
          pc_we = 1'b1;
          pc_d  = i_Redirect_Valid ? redirect_pc : r_pending;
        end
      end
      default: ;
    endcase
  end

  // PC and pending-redirect registers.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_pc      <= RESET_PC;
      r_pending <= RESET_PC;
    end else begin
      if (pc_we)   r_pc      <= pc_d;
      if (pend_we) r_pending <= pend_d;
    end
  end

  fetch_buffer #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fetch_buffer (
    .i_Clock  (i_Clock),
    .i_Reset  (i_Reset),
    .push     (push),
    .push_dat (push_entry),
    .pop      (pop),
    .flush    (flush),
    .full     (buf_full),
    .empty    (buf_empty),
    .count    (buf_count),
    .head_dat (head_entry)
  );

  // The issue-time slot reservation makes a push into a full buffer impossible.
  a_no_overflow: assert property (@(posedge i_Clock) disable iff (i_Reset)
                                  !(push && buf_full && !flush));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a behavioural instruction memory.
// Memory answers LAT cycles after the request is first seen, then drops valid for one cycle.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst;
  logic        halt;
  logic        redir;
  logic [31:0] redir_tgt;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_instr;
  logic        mem_vld;
  logic        instr_vld;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        dec_rdy;

  int tests = 0;
  int fails = 0;
  int lat   = 1;
  int cnt;

  instruction_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .i_Clock                 (clk),
    .i_Reset                 (rst),
    .i_Halt                  (halt),
    .i_Redirect_Valid        (redir),
    .i_Redirect_Target       (redir_tgt),
    .o_Mem_Enable            (mem_en),
    .o_Mem_Addr              (mem_addr),
    .i_Mem_Instruction       (mem_instr),
    .i_Mem_Instruction_Valid (mem_vld),
    .o_Instr_Valid           (instr_vld),
    .o_Instr                 (instr),
    .o_Instr_PC              (instr_pc),
    .i_Decode_Ready          (dec_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'hA000_0000 ^ a;
  endfunction

  // Instruction memory model sharing the fetch unit's reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_vld   <= 1'b0;
      mem_instr <= '0;
      cnt       <= 0;
    end else if (mem_vld) begin
      mem_vld <= 1'b0;
      cnt     <= 0;
    end else if (mem_en) begin
      if (cnt + 1 >= lat) begin
        mem_vld   <= 1'b1;
        mem_instr <= rom(mem_addr);
      end else begin
        cnt <= cnt + 1;
      end
    end else begin
      cnt <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; halt = 1'b0; redir = 1'b0; redir_tgt = '0; dec_rdy = 1'b1; lat = 1;
    #12;
    check("rst_en",      32'(mem_en),    32'd0);
    check("rst_ivld",    32'(instr_vld), 32'd0);
    check("rst_instr",   instr,          32'd0);
    check("rst_ipc",     instr_pc,       32'd0);
    check("rst_addr",    mem_addr,       32'd0);

    // Sequential ROM fetch, decode always ready.
    @(negedge clk); rst = 1'b0; #1;
    for (int k = 0; k < 4; k++) begin
      check("rom_issue_en",   32'(mem_en), 32'd1);
      check("rom_issue_addr", mem_addr,    32'(4 * k));
      @(negedge clk); #1;
      check("rom_wait_en",    32'(mem_en),    32'd1);
      check("rom_wait_ivld",  32'(instr_vld), 32'd0);
      check("rom_wait_addr",  mem_addr,       32'(4 * k));
      @(negedge clk); #1;
      check("rom_head_vld",   32'(instr_vld), 32'd1);
      check("rom_head_pc",    instr_pc,       32'(4 * k));
      check("rom_head_instr", instr,          rom(32'(4 * k)));
    end

    // Backpressure: head 0xC stays, 0x10 fills the second slot, issue stops.
    dec_rdy = 1'b0;
    check("bp_issue_addr", mem_addr, 32'h10);
    @(negedge clk); #1;
    check("bp_hold_pc", instr_pc, 32'hC);
    @(negedge clk); #1;
    check("bp_full_en",  32'(mem_en),    32'd0);
    check("bp_full_vld", 32'(instr_vld), 32'd1);
    check("bp_full_pc",  instr_pc,       32'hC);
    @(negedge clk); #1;
    check("bp_still_en", 32'(mem_en), 32'd0);
    dec_rdy = 1'b1;
    @(negedge clk); dec_rdy = 1'b0; #1;
    check("bp_pop_en",   32'(mem_en), 32'd1);
    check("bp_pop_addr", mem_addr,    32'h14);
    check("bp_pop_pc",   instr_pc,    32'h10);
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("bp_refull_en", 32'(mem_en), 32'd0);
    check("bp_refull_pc", instr_pc,    32'h10);

    // Redirect in idle (low bits ignored), then a slow read redirected mid-flight.
    lat = 6; dec_rdy = 1'b1; redir = 1'b1; redir_tgt = 32'h0000_1003; #1;
    check("ridle_en", 32'(mem_en), 32'd0);
    @(negedge clk); redir = 1'b0; #1;
    check("axi_flush_vld", 32'(instr_vld), 32'd0);
    check("axi_issue_en",  32'(mem_en),    32'd1);
    check("axi_issue_addr", mem_addr,      32'h1000);
    @(negedge clk); #1;
    check("axi_c1_addr", mem_addr, 32'h1000);
    @(negedge clk); redir = 1'b1; redir_tgt = 32'h20; #1;
    check("axi_c2_en",   32'(mem_en), 32'd1);
    check("axi_c2_addr", mem_addr,    32'h1000);
    @(negedge clk); redir = 1'b0;
    for (int c = 3; c < 6; c++) begin
      #1;
      check("drain_en",   32'(mem_en),    32'd1);
      check("drain_addr", mem_addr,       32'h1000);
      check("drain_ivld", 32'(instr_vld), 32'd0);
      @(negedge clk);
    end
    #1;
    check("drain_vcyc_en",   32'(mem_en), 32'd1);
    check("drain_vcyc_addr", mem_addr,    32'h1000);
    @(negedge clk); lat = 1; #1;
    check("post_drain_en",   32'(mem_en),    32'd1);
    check("post_drain_addr", mem_addr,       32'h20);
    check("post_drain_ivld", 32'(instr_vld), 32'd0);

    // Redirect on the same cycle as the response.
    @(negedge clk); redir = 1'b1; redir_tgt = 32'h40; #1;
    check("coinc_addr", mem_addr, 32'h20);
    @(negedge clk); redir = 1'b0; #1;
    check("coinc_ivld", 32'(instr_vld), 32'd0);
    check("coinc_en",   32'(mem_en),    32'd1);
    check("coinc_addr2", mem_addr,      32'h40);
    @(negedge clk); #1;
    @(negedge clk); lat = 4; #1;
    check("coinc_head_pc",    instr_pc, 32'h40);
    check("coinc_head_instr", instr,    rom(32'h40));
    check("seq_addr_44",      mem_addr, 32'h44);

    // Several redirects while draining; the last lands on the response cycle.
    @(negedge clk); redir = 1'b1; redir_tgt = 32'h80; #1;
    check("d1_addr", mem_addr, 32'h44);
    @(negedge clk); redir = 1'b1; redir_tgt = 32'h88; #1;
    check("d2_addr", mem_addr, 32'h44);
    @(negedge clk); redir = 1'b0; #1;
    check("d3_en", 32'(mem_en), 32'd1);
    @(negedge clk); redir = 1'b1; redir_tgt = 32'h90; #1;
    check("d4_addr", mem_addr, 32'h44);
    @(negedge clk); redir = 1'b0; #1;
    check("d5_en",   32'(mem_en),    32'd1);
    check("d5_addr", mem_addr,       32'h90);
    check("d5_ivld", 32'(instr_vld), 32'd0);

    // Asynchronous reset in the middle of a drain.
    @(negedge clk); redir = 1'b1; redir_tgt = 32'h100; #1;
    @(negedge clk); redir = 1'b0; #1;
    check("e2_addr", mem_addr, 32'h90);
    #1 rst = 1'b1; #1;
    check("arst_en",   32'(mem_en),    32'd0);
    check("arst_addr", mem_addr,       32'd0);
    check("arst_ivld", 32'(instr_vld), 32'd0);
    lat = 1;
    @(negedge clk);
    @(negedge clk); rst = 1'b0; #1;
    check("rel_en",   32'(mem_en),    32'd1);
    check("rel_addr", mem_addr,       32'd0);
    check("rel_ivld", 32'(instr_vld), 32'd0);

    // Halt raised while a read is in flight.
    @(negedge clk); halt = 1'b1; #1;
    check("halt_wait_en", 32'(mem_en), 32'd1);
    @(negedge clk); #1;
    check("halt_idle_en", 32'(mem_en),    32'd0);
    check("halt_push_vld", 32'(instr_vld), 32'd1);
    check("halt_push_pc", instr_pc,       32'd0);
    @(negedge clk); #1;
    check("halt_empty_en",  32'(mem_en),    32'd0);
    check("halt_empty_vld", 32'(instr_vld), 32'd0);

    // PC wrap from the top of the address space.
    redir = 1'b1; redir_tgt = 32'hFFFF_FFFF;
    @(negedge clk); redir = 1'b0; #1;
    check("wrap_halt_en", 32'(mem_en), 32'd0);
    check("wrap_addr",    mem_addr,    32'hFFFF_FFFC);
    halt = 1'b0; #1;
    check("wrap_issue_en", 32'(mem_en), 32'd1);
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("wrap_head_pc",    instr_pc, 32'hFFFF_FFFC);
    check("wrap_head_instr", instr,    rom(32'hFFFF_FFFC));
    check("wrap_next_addr",  mem_addr, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
